// File: rtl/mult_pkg.sv
// Shared constants for the 16x16 sequential shift-add multiplier.
// Holds the FSM state encoding, the operand width and the last iteration index.
package mult_pkg;
    localparam int unsigned MULT_W = 16;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [4:0] ITER_LAST = 5'd15;
endpackage

// File: rtl/rca_16_bit.sv
// 16-bit ripple-carry adder, purely combinational, no flow control.
// Sum and carry-out settle within the same cycle as the inputs.
module rca_16_bit (
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    output logic [15:0] o_sum,
    output logic        o_cout
);
    logic [16:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar g = 0; g < 16; g++) begin : g_fa
        assign o_sum[g]  = i_a[g] ^ i_b[g] ^ w_c[g];
        assign w_c[g+1]  = (i_a[g] & i_b[g]) | (w_c[g] & (i_a[g] ^ i_b[g]));
    end

    assign o_cout = w_c[16];
endmodule

// File: rtl/seq_mult_16_bit.sv
// Unsigned 16x16 shift-add multiplier: product valid 16 cycles after accept, plus one DONE cycle.
// No queuing: start is only sampled in IDLE, ignored while busy or done.
module seq_mult_16_bit
    import mult_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [MULT_W-1:0]       a,
    input  logic [MULT_W-1:0]       b,
    output logic                    busy,
    output logic                    done,
    output logic [2*MULT_W-1:0]     product
);
    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [MULT_W-1:0]   r_mcand;
    logic [MULT_W-1:0]   r_acc_hi;
    logic [MULT_W-1:0]   r_acc_lo;
    logic [4:0]          r_cnt;
    logic [2*MULT_W-1:0] r_product;

    logic [MULT_W-1:0]   w_addend;
    logic [MULT_W-1:0]   w_sum;
    logic                w_cout;
    logic [2*MULT_W-1:0] w_acc_next;

    assign w_addend = r_acc_lo[0] ? r_mcand : '0;

    rca_16_bit u_rca (
        .i_a    (r_acc_hi),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // {cout, sum, acc_lo} shifted right by one; the carry lands in bit 31.
    assign w_acc_next = {w_cout, w_sum, r_acc_lo[MULT_W-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = IDLE;
        case (r_state)
            IDLE:    w_next_state = start ? RUN : IDLE;
            RUN:     w_next_state = (r_cnt == ITER_LAST) ? DONE : RUN;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == RUN);
        done = (r_state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_acc_hi <= '0;
                        r_acc_lo <= b;
                        r_cnt    <= '0;
                    end
                end
                RUN: begin
                    r_acc_hi <= w_acc_next[2*MULT_W-1:MULT_W];
                    r_acc_lo <= w_acc_next[MULT_W-1:0];
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == ITER_LAST) begin
                        r_product <= w_acc_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign product = r_product;
endmodule
